data_memory_pipe: RTL and testbench

- Parametrised single-port synchronous data memory for the 16-bit MIPS datapath, replacing the combinational-read data memory.
- Adds a valid/ready request handshake, byte-lane write enables, and a configurable registered read latency.
- Zero-fills every word after reset and flags out-of-range addresses.
- Sits between the MEM stage and the load/store path; the pipeline stalls on req_ready low.

---
 rtl/data_memory_pipe_if.sv | 26 ++
 rtl/data_memory_pipe.sv | 114 +++++++++++
 tb/tb_data_memory_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pipe_if.sv
// Request/response bundle between the MEM stage and the synchronous data memory.
// The master issues word-addressed loads/stores; the slave returns in-order load responses.
interface data_memory_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_valid;
  logic                    addr_err;

  modport master (
    output req_valid, req_write, address, store_data, byte_en,
    input  req_ready, load_data, load_valid, addr_err
  );

  modport slave (
    input  req_valid, req_write, address, store_data, byte_en,
    output req_ready, load_data, load_valid, addr_err
  );
endinterface

// File: rtl/data_memory_pipe.sv
// Single-port synchronous data memory with byte-lane stores, zero-fill after reset,
// out-of-range flagging and a READ_LATENCY-deep registered load response path.
module data_memory_pipe #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_memory_pipe_if.slave   bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST   = READ_LATENCY - 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        clear_ptr_reg;
  logic                    ready;
  logic                    accept;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_reg;
  logic [READ_LATENCY-1:0] err_reg;
  logic [DATA_WIDTH-1:0]   data_reg [READ_LATENCY];

  // Compare one bit wider than the port so DEPTH == 2**ADDR_WIDTH still works.
  assign in_range = {1'b0, bus.address} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx      = bus.address[IDX_W-1:0];
  assign accept   = bus.req_valid && ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clear_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == CLEAR) begin
        if (clear_ptr_reg == IDX_W'(DEPTH - 1))
          clear_ptr_reg <= '0;
        else
          clear_ptr_reg <= clear_ptr_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      CLEAR: begin
        if (clear_ptr_reg == IDX_W'(DEPTH - 1))
          state_next = READY;
      end
      READY: begin
        ready = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  // Clear sweep and byte-lane stores share the single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == CLEAR) begin
        mem[clear_ptr_reg] <= '0;
      end else if (accept && bus.req_write && in_range) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (bus.byte_en[b])
            mem[idx][8*b +: 8] <= bus.store_data[8*b +: 8];
        end
      end
    end
  end

  // Stage 0: the registered array read. Data only moves on a load so the
  // output naturally holds its last response between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg[0]  <= 1'b0;
      err_reg[0]  <= 1'b0;
      data_reg[0] <= '0;
    end else begin
      vld_reg[0] <= accept && !bus.req_write;
      err_reg[0] <= accept && !in_range;
      if (accept && !bus.req_write)
        data_reg[0] <= in_range ? mem[idx] : '0;
    end
  end

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg[gi]  <= 1'b0;
        err_reg[gi]  <= 1'b0;
        data_reg[gi] <= '0;
      end else begin
        vld_reg[gi] <= vld_reg[gi-1];
        err_reg[gi] <= err_reg[gi-1];
        if (vld_reg[gi-1])
          data_reg[gi] <= data_reg[gi-1];
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.load_valid = vld_reg[LAST];
  assign bus.addr_err   = err_reg[LAST];
  assign bus.load_data  = data_reg[LAST];
endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench for data_memory_pipe: responses are predicted into a queue when a
// request is accepted and checked, including their arrival cycle, when the DUT emits them.
module tb_data_memory_pipe;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  typedef struct {
    int          due;
    bit          valid;
    bit          err;
    logic [15:0] data;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  resp_t sb[$];

  data_memory_pipe_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  data_memory_pipe #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest prediction, on its cycle.
  always @(negedge clk) begin
    resp_t e;
    if (bus.load_valid === 1'b1 || bus.addr_err === 1'b1) begin
      chk("unexpected_pulse", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("load_valid", 32'(bus.load_valid), 32'(e.valid));
        chk("addr_err", 32'(bus.addr_err), 32'(e.err));
        if (e.valid)
          chk("load_data", 32'(bus.load_data), 32'(e.data));
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("missing_resp", 32'(sb[0].due), 32'(cyc));
      void'(sb.pop_front());
    end
  end

  task automatic req(input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] be, input logic [15:0] exp);
    resp_t r;
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.address    = a;
    bus.store_data = d;
    bus.byte_en    = be;
    @(posedge clk);
    #1;
    $display("req %s addr=%04h data=%04h be=%b accepted_cycle=%0d",
             wr ? "store" : "load ", a, d, be, cyc);
    if (!wr || a >= 16'(DEPTH)) begin
      r.due   = cyc + LAT - 1;
      r.valid = !wr;
      r.err   = (a >= 16'(DEPTH));
      r.data  = exp;
      sb.push_back(r);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    req(1'b1, a, d, be, 16'h0000);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] exp);
    req(1'b0, a, 16'h0000, 2'b00, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
  endtask

  // Holds rst for n rising edges, checks the reset outputs, then releases at a falling edge.
  task automatic do_reset(input int n);
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    sb.delete();
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_load_valid", 32'(bus.load_valid), 32'd0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst_load_data", 32'(bus.load_data), 32'd0);
    $display("reset held %0d edges, released at cycle %0d", n, cyc);
    rst = 1'b0;
  endtask

  // Called at the release edge: counts low-ready cycles until the clear sweep ends.
  task automatic check_clear();
    int cnt = 0;
    while (bus.req_ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    $display("clear finished after %0d cycles", cnt);
    chk("clear_cycles", 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.address    = '0;
    bus.store_data = '0;
    bus.byte_en    = '0;

    // Reset and zero-fill
    do_reset(2);
    check_clear();
    load(16'h0000, 16'h0000);
    load(16'h0011, 16'h0000);
    load(16'h00FF, 16'h0000);
    idle(3);

    // Store/load round trip, load immediately after the store
    store(16'h0040, 16'hBEEF, 2'b11);
    load(16'h0040, 16'hBEEF);
    idle(3);

    // Byte lanes, including an all-disabled store
    store(16'h0010, 16'h1234, 2'b11);
    store(16'h0010, 16'hAB00, 2'b10);
    store(16'h0010, 16'h00CD, 2'b00);
    load(16'h0010, 16'hAB34);
    store(16'h0011, 16'h5566, 2'b01);
    load(16'h0011, 16'h0066);
    idle(3);

    // Back-to-back loads
    for (int i = 1; i <= 4; i++) store(16'(i), 16'(i), 2'b11);
    for (int i = 1; i <= 4; i++) load(16'(i), 16'(i));
    idle(4);
    chk("hold_load_data", 32'(bus.load_data), 32'h0004);
    chk("hold_load_valid", 32'(bus.load_valid), 32'd0);

    // Out-of-range requests, and the top legal word left untouched
    store(16'h0100, 16'hFFFF, 2'b11);
    load(16'h0100, 16'h0000);
    load(16'h00FF, 16'h0000);
    load(16'hFFFF, 16'h0000);
    idle(4);

    // Reset with a load in flight: no pulse, load_data cleared
    load(16'h0040, 16'hBEEF);
    idle(3);
    load(16'h0040, 16'hBEEF);
    do_reset(1);
    check_clear();
    load(16'h0040, 16'h0000);
    store(16'h0020, 16'h7777, 2'b11);
    idle(2);

    // Reset mid-clear restarts the sweep from zero
    rst = 1'b1;
    idle(1);
    do_reset(1);
    repeat (100) @(negedge clk);
    do_reset(1);
    check_clear();
    load(16'h0020, 16'h0000);
    load(16'h0010, 16'h0000);
    idle(6);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
